mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_port_arbiter: FSM states, owner ids and access-size codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker. Define MEM_ARB_RR_EN for round-robin on conflicts,
// otherwise data has fixed priority over inst. grant[0] = inst, grant[1] = data.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
      grant = (last_owner == OWN_DATA) ? 2'b01 : 2'b10;
`else
      grant = 2'b10;
`endif
    end else if (data_req) begin
      grant = 2'b10;
    end else if (inst_req) begin
      grant = 2'b01;
    end
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters, one transaction
// at a time. MEM_ARB_RR_EN selects round-robin arbitration instead of data-first priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  accept;
  logic [1:0]            grant;
  logic                  last_owner;

  logic                  wr_q;
  logic [1:0]            size_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic [DATA_W-1:0]     wdata_q;

  mem_arb_pick u_pick (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_owner (last_owner),
    .grant      (grant)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          accept  = 1'b1;
          owner_d = grant[1] ? OWN_DATA : OWN_INST;
          state_d = StAddr;
        end
      end
      StAddr: if (mem_addr_ok) state_d = StData;
      StData: if (mem_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (accept) begin
        wr_q    <= grant[1] ? data_wr    : inst_wr;
        size_q  <= grant[1] ? data_size  : inst_size;
        addr_q  <= grant[1] ? data_addr  : inst_addr;
        wstrb_q <= grant[1] ? data_wstrb : inst_wstrb;
        wdata_q <= grant[1] ? data_wdata : inst_wdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  logic last_owner_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner_q <= OWN_INST;
    end else if (accept) begin
      last_owner_q <= owner_d;
    end
  end
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_INST;
`endif

  // Gated by reset so a held request cannot be acked while reset is asserted.
  assign inst_addr_ok = accept & grant[0] & ~reset;
  assign data_addr_ok = accept & grant[1] & ~reset;

  assign inst_data_ok = (state_q == StData) & mem_data_ok & (owner_q == OWN_INST);
  assign data_data_ok = (state_q == StData) & mem_data_ok & (owner_q == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign mem_req   = (state_q == StAddr);
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

endmodule
